// File: rtl/seg_reader.sv
// Scanned 7-segment display reader: debounces each digit slot and decodes its segment pattern to hex.
// Optional decimal-point capture is enabled by defining SEG_READER_DP_EN.
module seg_reader #(
  parameter int STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  input  logic [3:0]  digit,
  output logic [3:0]  code,
  output logic [1:0]  pos,
  output logic        dp_o,
  output logic [15:0] value,
  output logic        valid,
  output logic        err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] sample_q;
  logic [3:0]  code_q, code_d;
  logic [1:0]  pos_q, pos_d;
  logic        dp_q, dp_d;
  logic [15:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        dp_s;
  logic [11:0] word_s;
  logic        onehot_s;
  logic        same_s;
  logic [4:0]  dec_s;
  logic [1:0]  sel_s;

`ifdef SEG_READER_DP_EN
  assign dp_s = dp;
`else
  // dp is excluded from the compare so a flickering point never delays acceptance.
  logic unused_dp_s;
  assign unused_dp_s = dp;
  assign dp_s        = 1'b0;
`endif

  // {legal, hex} for a gfedcba pattern; blank and garbage both report not-legal.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   seg_decode = {1'b1, 4'h0};
      7'h06:   seg_decode = {1'b1, 4'h1};
      7'h5B:   seg_decode = {1'b1, 4'h2};
      7'h4F:   seg_decode = {1'b1, 4'h3};
      7'h66:   seg_decode = {1'b1, 4'h4};
      7'h6D:   seg_decode = {1'b1, 4'h5};
      7'h7D:   seg_decode = {1'b1, 4'h6};
      7'h07:   seg_decode = {1'b1, 4'h7};
      7'h7F:   seg_decode = {1'b1, 4'h8};
      7'h6F:   seg_decode = {1'b1, 4'h9};
      7'h77:   seg_decode = {1'b1, 4'hA};
      7'h7C:   seg_decode = {1'b1, 4'hB};
      7'h39:   seg_decode = {1'b1, 4'hC};
      7'h5E:   seg_decode = {1'b1, 4'hD};
      7'h79:   seg_decode = {1'b1, 4'hE};
      7'h71:   seg_decode = {1'b1, 4'hF};
      default: seg_decode = 5'b0_0000;
    endcase
  endfunction

  function automatic logic [1:0] pos_encode(input logic [3:0] dig);
    case (dig)
      4'b0010: pos_encode = 2'd1;
      4'b0100: pos_encode = 2'd2;
      4'b1000: pos_encode = 2'd3;
      default: pos_encode = 2'd0;
    endcase
  endfunction

  assign word_s   = {digit, g, f, e, d, c, b, a, dp_s};
  assign onehot_s = (digit == 4'b0001) || (digit == 4'b0010) ||
                    (digit == 4'b0100) || (digit == 4'b1000);
  assign same_s   = (word_s == sample_q);
  assign dec_s    = seg_decode(sample_q[7:1]);
  assign sel_s    = pos_encode(sample_q[11:8]);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pos_d   = pos_q;
    dp_d    = dp_q;
    value_d = value_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (!onehot_s || !same_s) begin
      cnt_d = 8'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (onehot_s) begin
          state_d = COUNT;
        end else begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        if (!onehot_s) begin
          state_d = IDLE;
        end else if (cnt_d == CNT_MAX) begin
          // The input equals sample_q here, so decode the registered copy.
          state_d = DONE;
          if (dec_s[4]) begin
            valid_d                    = 1'b1;
            code_d                     = dec_s[3:0];
            pos_d                      = sel_s;
            dp_d                       = sample_q[0];
            value_d[{sel_s, 2'b00} +: 4] = dec_s[3:0];
          end else if (sample_q[7:1] != 7'h00) begin
            err_d = 1'b1;
            pos_d = sel_s;
          end else begin
            err_d = 1'b0;
          end
        end else begin
          state_d = COUNT;
        end
      end
      DONE: begin
        if (same_s) begin
          state_d = DONE;
        end else if (onehot_s) begin
          state_d = COUNT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      sample_q <= 12'h000;
      code_q   <= 4'h0;
      pos_q    <= 2'd0;
      dp_q     <= 1'b0;
      value_q  <= 16'h0000;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= word_s;
      code_q   <= code_d;
      pos_q    <= pos_d;
      dp_q     <= dp_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign code  = code_q;
  assign pos   = pos_q;
  assign value = value_q;
  assign valid = valid_q;
  assign err   = err_q;
`ifdef SEG_READER_DP_EN
  assign dp_o  = dp_q;
`else
  assign dp_o  = 1'b0;
`endif

endmodule

// File: tb/tb_seg_reader.sv
// Randomized scoreboard bench for seg_reader: a run-length reference model predicts events,
// a negedge monitor pops and compares them and the persistent outputs.
module tb_seg_reader;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a, b, c, d, e, f, g, dp;
  logic [3:0]  digit;
  logic [3:0]  code;
  logic [1:0]  pos;
  logic        dp_o;
  logic [15:0] value;
  logic        valid, err;

  seg_reader #(.STABLE_CYC(S)) dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .digit(digit),
    .code(code), .pos(pos), .dp_o(dp_o), .value(value),
    .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int edge_n;
    bit is_err;
  } ev_t;

  ev_t evq[$];
  int  checks = 0;
  int  errors = 0;
  int  edge_n = 0;
  int  nvalid = 0;
  int  nerr   = 0;
  bit  mon_en = 1'b0;

  logic [3:0]  exp_code;
  logic [1:0]  exp_pos;
  logic        exp_dp;
  logic [15:0] exp_value;
  int          run;
  logic [11:0] prev_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int lut(input logic [6:0] s);
    lut = -1;
    for (int i = 0; i < 16; i++) begin
      if (PAT[i] == s) lut = i;
    end
  endfunction

  function automatic int onehot_idx(input logic [3:0] dg);
    case (dg)
      4'b0001: onehot_idx = 0;
      4'b0010: onehot_idx = 1;
      4'b0100: onehot_idx = 2;
      4'b1000: onehot_idx = 3;
      default: onehot_idx = -1;
    endcase
  endfunction

  // Reference model: a word seen on S+1 consecutive edges is accepted exactly once.
  always @(posedge clk) begin
    logic [11:0] w;
    logic        dpm;
    int          p, k;
    edge_n++;
    if (rst) begin
      run = 0;
      exp_code = 4'h0; exp_pos = 2'd0; exp_dp = 1'b0; exp_value = 16'h0000;
    end else begin
`ifdef SEG_READER_DP_EN
      dpm = dp;
`else
      dpm = 1'b0;
`endif
      w = {digit, g, f, e, d, c, b, a, dpm};
      if (run > 0 && w == prev_w) run++;
      else run = 1;
      prev_w = w;
      p = onehot_idx(digit);
      if (p >= 0 && run == S + 1) begin
        k = lut({g, f, e, d, c, b, a});
        if (k >= 0) begin
          evq.push_back('{edge_n, 1'b0});
          exp_code = 4'(k);
          exp_pos  = 2'(p);
          exp_dp   = dpm;
          exp_value[p*4 +: 4] = 4'(k);
        end else if ({g, f, e, d, c, b, a} != 7'h00) begin
          evq.push_back('{edge_n, 1'b1});
          exp_pos = 2'(p);
        end
      end
    end
  end

  // Monitor: compares persistent outputs every cycle and pops the scoreboard on each event.
  always @(negedge clk) begin
    ev_t ev;
    if (mon_en) begin
      chk("code", 32'(code), 32'(exp_code));
      chk("pos", 32'(pos), 32'(exp_pos));
      chk("dp_o", 32'(dp_o), 32'(exp_dp));
      chk("value", 32'(value), 32'(exp_value));
      if (valid && err) chk("valid_err_exclusive", 32'(valid & err), 32'd0);
      if (valid) nvalid++;
      if (err) nerr++;
      if (valid || err) begin
        chk("event_expected", 32'(evq.size() != 0), 32'd1);
        if (evq.size() != 0) begin
          ev = evq.pop_front();
          chk("event_edge", 32'(edge_n), 32'(ev.edge_n));
          chk("event_is_err", 32'(err), 32'(ev.is_err));
        end
      end else if (evq.size() != 0 && evq[0].edge_n <= edge_n) begin
        chk("event_missing", 32'(valid | err), 32'd1);
        void'(evq.pop_front());
      end
    end
  end

  task automatic hold(input logic [3:0] dg, input logic [6:0] sg, input logic dv, input int n);
    @(negedge clk);
    digit = dg;
    {g, f, e, d, c, b, a} = sg;
    dp = dv;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int v0, e0, dg_sel, sg_sel;
    logic [3:0] rdg;
    logic [6:0] rsg;
    digit = 4'b0000; {g, f, e, d, c, b, a} = 7'h00; dp = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_value", 32'(value), 32'h0000);
    rst = 1'b0;

    // Single digit accepted
    v0 = nvalid;
    hold(4'b0001, 7'h5B, 1'b0, S + 2);
    @(negedge clk);
    chk("d1_nvalid", 32'(nvalid - v0), 32'd1);
    chk("d1_value", 32'(value), 32'h0002);
    chk("d1_code", 32'(code), 32'd2);

    // Two positions
    v0 = nvalid;
    hold(4'b0100, 7'h71, 1'b0, S + 2);
    hold(4'b1000, 7'h3F, 1'b0, S + 2);
    @(negedge clk);
    chk("d2_nvalid", 32'(nvalid - v0), 32'd2);
    chk("d2_value", 32'(value), 32'h0F02);
    chk("d2_pos", 32'(pos), 32'd3);

    // Change during count restarts
    v0 = nvalid;
    hold(4'b0010, 7'h06, 1'b0, 3);
    hold(4'b0010, 7'h4F, 1'b0, S + 2);
    @(negedge clk);
    chk("d3_nvalid", 32'(nvalid - v0), 32'd1);
    chk("d3_code", 32'(code), 32'd3);
    chk("d3_pos", 32'(pos), 32'd1);

    // Illegal, blank and multi-hot patterns
    v0 = nvalid; e0 = nerr;
    hold(4'b0001, 7'h55, 1'b0, S + 2);
    @(negedge clk);
    chk("d4_nerr", 32'(nerr - e0), 32'd1);
    chk("d4_pos", 32'(pos), 32'd0);
    chk("d4_value", 32'(value), 32'h0F32);
    e0 = nerr;
    hold(4'b0001, 7'h00, 1'b0, 10);
    hold(4'b0011, 7'h06, 1'b0, 10);
    @(negedge clk);
    chk("d5_no_event", 32'((nvalid - v0) + (nerr - e0)), 32'd0);

    // Reset on the third stable cycle
    hold(4'b0010, 7'h66, 1'b0, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("d6_reset_value", 32'(value), 32'h0000);
    chk("d6_reset_code", 32'(code), 32'd0);
    v0 = nvalid;
    repeat (S + 2) @(posedge clk);
    @(negedge clk);
    chk("d6_nvalid", 32'(nvalid - v0), 32'd1);
    chk("d6_value", 32'(value), 32'h0040);

    // Decimal point capture
    hold(4'b0001, 7'h7F, 1'b1, S + 2);
    @(negedge clk);
`ifdef SEG_READER_DP_EN
    chk("d7_dp_o", 32'(dp_o), 32'd1);
`else
    chk("d7_dp_o", 32'(dp_o), 32'd0);
    v0 = nvalid;
    hold(4'b0100, 7'h07, 1'b0, 1);
    for (int i = 0; i < S + 1; i++) begin
      @(negedge clk);
      dp = ~dp;
      @(posedge clk);
    end
    @(negedge clk);
    chk("d7_dp_toggle_nvalid", 32'(nvalid - v0), 32'd1);
`endif

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      dg_sel = $urandom_range(0, 9);
      rdg = (dg_sel < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      sg_sel = $urandom_range(0, 19);
      if (sg_sel < 12) rsg = PAT[$urandom_range(0, 15)];
      else if (sg_sel < 15) rsg = 7'h00;
      else rsg = 7'($urandom_range(0, 127));
      hold(rdg, rsg, 1'($urandom_range(0, 1)), $urandom_range(1, 8));
      if ($urandom_range(0, 40) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    hold(4'b0000, 7'h00, 1'b0, 4);
    @(negedge clk);
    chk("scoreboard_drained", 32'(evq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_reader.md
SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter STABLE_CYC, default 4, SHALL set the number of consecutive unchanged samples needed to accept a digit (legal range 2..255).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a, b, c, d, e, f, g  input  1 each  segment lines, active-high, from a scanned 7-segment display.
REQ-005 dp  input  1  decimal-point line, active-high.
REQ-006 digit  input  4  digit-position select, one-hot, active-high; bit n selects position n.
REQ-007 code  output  4  hex value of the last accepted digit.
REQ-008 pos  output  2  position of the last accepted digit or error.
REQ-009 dp_o  output  1  dp state of the last accepted digit.
REQ-010 value  output  16  accepted hex codes per position; value[4n+3:4n] holds position n.
REQ-011 valid  output  1  one-cycle pulse when a legal digit is accepted.
REQ-012 err  output  1  one-cycle pulse when an illegal non-blank pattern is accepted.

Function
REQ-013 The block SHALL register the input word {digit, g..a, dp} every cycle and compare each new input word with the registered one.
REQ-014 A stability counter SHALL increment on equal words, saturate at STABLE_CYC, and clear to 0 on any difference.
REQ-015 The FSM SHALL have three states: IDLE, COUNT and DONE.
REQ-016 IDLE SHALL be entered whenever digit is not exactly one-hot (zero or multi-hot); the counter SHALL clear and no event SHALL be produced.
REQ-017 IDLE SHALL go to COUNT when a one-hot digit is present.
REQ-018 COUNT SHALL go to DONE when the counter reaches STABLE_CYC, and SHALL evaluate the pattern on that same edge.
REQ-019 DONE SHALL hold with no further events until the input word changes, then go to COUNT (one-hot) or IDLE (otherwise).
REQ-020 Latency: with the input word stable from before edge k, valid/err SHALL be high from edge k+STABLE_CYC to edge k+STABLE_CYC+1 (exactly one cycle).
REQ-021 Decode, gfedcba hex -> code: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->b, 39->C, 5E->d, 79->E, 71->F.
REQ-022 A legal pattern SHALL pulse valid and update code, pos, dp_o and the selected nibble of value; all other nibbles SHALL be unchanged.
REQ-023 Segment pattern 00 (blank) SHALL produce no event and leave all outputs unchanged.
REQ-024 Any other pattern SHALL pulse err, update pos, and leave code, dp_o and value unchanged.
REQ-025 valid and err SHALL never be high in the same cycle.
REQ-026 A change of any input bit during COUNT SHALL restart the count from the changed word; no partial acceptance SHALL occur.

Reset
REQ-027 With rst high at a rising edge, all of the following SHALL take effect at that edge, including mid-count or in DONE, and no event SHALL be emitted:
  - code=0, pos=0, dp_o=0, value=16'h0000, valid=0, err=0;
  - counter=0, sample register=0, state=IDLE.
REQ-028 After release, a pattern already present SHALL need the full STABLE_CYC count before it is accepted.

Configuration
REQ-029 Macro SEG_READER_DP_EN selects decimal-point handling.
REQ-030 SEG_READER_DP_EN defined: dp SHALL be part of the stability compare and SHALL be captured into dp_o on valid.
REQ-031 SEG_READER_DP_EN undefined: dp SHALL be ignored (excluded from the compare) and dp_o SHALL be tied to 0.

Verification
REQ-032 Reset, digit=4'b0001, segments=7'h5B held 4 cycles -> valid pulses once; code=2, pos=0, value=16'h0002.
REQ-033 digit=4'b0100, segments=7'h71 held 4 cycles, then digit=4'b1000, segments=7'h3F held 4 cycles -> value=16'h0F02, code=0, pos=3, two valid pulses total.
REQ-034 digit=4'b0010, segments=7'h06 for 3 cycles, change to 7'h4F for 4 cycles -> exactly one valid, code=3, pos=1.
REQ-035 Segment sweeps:
  - segments=7'h55 with digit=4'b0001, held 4 cycles -> err pulse, pos=0, value unchanged;
  - segments=7'h00 held 10 cycles -> no event;
  - digit=4'b0011 held 10 cycles -> no event.
REQ-036 Counted pattern with rst asserted on the 3rd stable cycle -> no event and all outputs at reset values; the held pattern is then accepted 4 cycles after release.
REQ-037 SEG_READER_DP_EN build: segments=7'h7F with dp=1 held 4 cycles -> dp_o=1. Same stimulus without the macro -> dp_o=0, and toggling dp during the count does not delay valid.
